decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode and operand-fetch stage that sits directly upstream of the 16-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. It sign-extends immediates and presents a registered {a, b, opcode, rd} bundle to the ALU. A writeback port from the ALU result path updates the register file, and a same-cycle bypass covers simultaneous write and read.

## Interface
- `DEPTH`, 8: register count; fixed at 8 (3-bit addresses).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage can accept an instruction this cycle.
- `in_instr` in 16: instruction word.
- `out_valid` out 1: ALU bundle is valid.
- `out_ready` in 1: downstream consumes the bundle this cycle.
- `alu_a` out 16: signed operand A, value of rs.
- `alu_b` out 16: signed operand B, either rt or the sign-extended imm7.
- `alu_opcode` out 3: operation code for the ALU.
- `alu_rd` out 3: destination register, carried through for writeback.
- `alu_wen` out 1: the bundle writes a register (0 for NOP/unsupported).
- `wb_en` in 1: writeback strobe.
- `wb_addr` in 3: writeback register.
- `wb_data` in 16: writeback value.

## Operation
- Instruction format: [15:13] opcode, [12:10] rd, [9:7] rs.
  - R-type (000 ADD): [6:4] rt, [3:0] ignored.
  - I-type (001 ADDI, 010 SUBI): [6:0] imm7, two's complement, sign-extended to 16 bits.
- Opcodes 011–111 are NOPs:
  - forward opcode unchanged, a = b = 0, alu_wen = 0;
  - they occupy one pipeline slot.
- r0 is hardwired to zero:
  - reads return 0;
  - writes to r0 are ignored.
  - rd = 0 still gives alu_wen = 1; the write is simply discarded.
- Writeback: when `wb_en`=1 and `wb_addr`≠0, `regs[wb_addr]` ← `wb_data` at the edge.
- Bypass: if `wb_en`=1 and `wb_addr` equals rs or rt (≠0) in the accept cycle, the operand takes `wb_data`, not the stale register.
- Output register is a single entry:
  - `in_ready` = !out_valid || out_ready (combinational);
  - accept fires on in_valid && in_ready (gated by the scoreboard, see Configuration).
- On accept: the bundle register loads and `out_valid` ← 1.
- When out_ready=1 and nothing is accepted: `out_valid` ← 0.
- While out_valid=1 and out_ready=0: the bundle holds stable, and in_ready=0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Reset values: out_valid=0, alu_a=0, alu_b=0, alu_opcode=0, alu_rd=0, alu_wen=0, all registers 0, scoreboard 0.
  - in_ready=1 after reset (when the scoreboard is compiled out, or when it is clear).
- Reset mid-operation: the bundle in flight is dropped immediately (async). No partial writeback occurs.
- Simultaneous accept and drain (out_valid=1, out_ready=1, in_valid=1): the new bundle replaces the old in the same edge, and out_valid stays 1.
- Writeback has priority over nothing. It is independent of the handshake and accepted every cycle, including during stall.

## Configuration
- Macro `DECODE_SCOREBOARD_EN`.
- Defined:
  - an 8-bit pending vector tracks registers with a write in flight;
  - on accept with alu_wen=1 and rd≠0, `pending[rd]` is set;
  - on wb_en with wb_addr≠0, `pending[wb_addr]` is cleared;
  - if both hit the same register in one cycle, set wins;
  - an instruction whose rs (or rt, R-type only) is pending and not bypassed this cycle is stalled: in_ready=0.
- Not defined:
  - no pending vector;
  - in_ready depends only on the output register;
  - hazard avoidance is the program's responsibility.

## Test plan
- Reset, then writeback r1=5 and r2=7, then ADD r3,r1,r2 with out_ready=1 → next cycle out_valid=1, a=5, b=7, opcode=000, rd=3, alu_wen=1.
- SUBI r4,r1,imm7=0x7F → b=16'hFFFF (−1) and a=5; imm7=0x3F → b=63.
- Bypass: wb_en to r1=100 in the same cycle as accepting ADDI r2,r1,1 → a=100. Read of r0 after a write to r0 → a=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, and the bundle is stable for all 3 cycles. Release → back-to-back bundles, with no loss or duplication.
- `DECODE_SCOREBOARD_EN`: ADD r3,... then ADD r5,r3,r1 → the second instruction stalls (in_ready=0) until wb_en r3. It is accepted in the wb cycle with a = wb_data.
- Assert rst while out_valid=1 → out_valid=0, all outputs 0, and registers read 0 afterward.

Source files
------------

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage ahead of the 16-bit ALU: 8x16 register file with
// writeback bypass and a single-entry output register. Optional hazard scoreboard: DECODE_SCOREBOARD_EN.
module decode_stage #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_opcode,
    output logic [2:0]  alu_rd,
    output logic        alu_wen,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data
);

    logic [15:0] regs [DEPTH];

    logic [2:0]  dec_opcode;
    logic [2:0]  dec_rd;
    logic [15:0] imm_ext;
    logic        is_rtype;
    logic        is_itype;
    logic        uses_rs;
    logic [15:0] dec_a;
    logic [15:0] dec_b;
    logic        dec_wen;
    logic        hazard;
    logic        accept;

    logic        out_valid_reg;
    logic [15:0] alu_a_reg;
    logic [15:0] alu_b_reg;
    logic [2:0]  alu_opcode_reg;
    logic [2:0]  alu_rd_reg;
    logic        alu_wen_reg;

    // Source port 0 reads rs, port 1 reads rt.
    logic [2:0]  src_addr [2];
    logic [15:0] src_val  [2];

    assign dec_opcode  = in_instr[15:13];
    assign dec_rd      = in_instr[12:10];
    assign src_addr[0] = in_instr[9:7];
    assign src_addr[1] = in_instr[6:4];
    assign imm_ext     = {{9{in_instr[6]}}, in_instr[6:0]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            // r0 reads zero even when a write to r0 is on the bus.
            always_comb begin
                src_val[gi] = '0;
                if (src_addr[gi] != 3'd0) begin
                    if (wb_en && (wb_addr == src_addr[gi])) begin
                        src_val[gi] = wb_data;
                    end else begin
                        src_val[gi] = regs[src_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        is_rtype = (dec_opcode == 3'b000);
        is_itype = (dec_opcode == 3'b001) || (dec_opcode == 3'b010);
        uses_rs  = is_rtype || is_itype;
        dec_wen  = uses_rs;
        dec_a    = '0;
        dec_b    = '0;
        if (uses_rs) begin
            dec_a = src_val[0];
        end
        if (is_rtype) begin
            dec_b = src_val[1];
        end else if (is_itype) begin
            dec_b = imm_ext;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic             rs_hazard;
    logic             rt_hazard;

    always_comb begin
        rs_hazard = uses_rs && (src_addr[0] != 3'd0) && pending_reg[src_addr[0]]
                    && !(wb_en && (wb_addr == src_addr[0]));
        rt_hazard = is_rtype && (src_addr[1] != 3'd0) && pending_reg[src_addr[1]]
                    && !(wb_en && (wb_addr == src_addr[1]));
        hazard    = rs_hazard || rt_hazard;
    end

    // Clear first so that a same-cycle set on the same register wins.
    always_comb begin
        pending_next = pending_reg;
        if (wb_en && (wb_addr != 3'd0)) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (accept && dec_wen && (dec_rd != 3'd0)) begin
            pending_next[dec_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    assign in_ready = (!out_valid_reg || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 3'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_opcode_reg <= '0;
            alu_rd_reg     <= '0;
            alu_wen_reg    <= 1'b0;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            alu_a_reg      <= dec_a;
            alu_b_reg      <= dec_b;
            alu_opcode_reg <= dec_opcode;
            alu_rd_reg     <= dec_rd;
            alu_wen_reg    <= dec_wen;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_opcode = alu_opcode_reg;
    assign alu_rd     = alu_rd_reg;
    assign alu_wen    = alu_wen_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand sequences
// and randomized traffic against a behavioural model (also covers DECODE_SCOREBOARD_EN builds).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [2:0]  alu_rd;
    logic        alu_wen;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_rd(alu_rd), .alu_wen(alu_wen),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic        wen;
    } bundle_t;

    typedef struct {
        logic        wbe;
        logic [2:0]  wba;
        logic [15:0] wbd;
        logic [15:0] instr;
        bundle_t     exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] mregs [8];
    bit          mpend [8];
    bit          mvalid;
    bundle_t     mb;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [6:0] low);
        return {op, rd, rs, low};
    endfunction

    function automatic bundle_t mk(input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] op, input logic [2:0] rd, input logic wen);
        bundle_t r;
        r.a = a; r.b = b; r.op = op; r.rd = rd; r.wen = wen;
        return r;
    endfunction

    // Operand value as the program sees it: r0 is zero, a concurrent write is visible.
    function automatic logic [15:0] mread(input int addr);
        if (addr == 0) return 16'd0;
        if (wb_en && (int'(wb_addr) == addr)) return wb_data;
        return mregs[addr];
    endfunction

    function automatic bundle_t mdecode(input logic [15:0] instr);
        bundle_t r;
        int op  = int'(instr[15:13]);
        int rs  = int'(instr[9:7]);
        int rt  = int'(instr[6:4]);
        int imm = int'(instr[6:0]);
        if (imm > 63) imm = imm - 128;
        r.op = instr[15:13];
        r.rd = instr[12:10];
        if (op == 0) begin
            r.a = mread(rs); r.b = mread(rt); r.wen = 1'b1;
        end else if (op == 1 || op == 2) begin
            r.a = mread(rs); r.b = 16'(imm); r.wen = 1'b1;
        end else begin
            r.a = 16'd0; r.b = 16'd0; r.wen = 1'b0;
        end
        return r;
    endfunction

    function automatic bit blocked(input int addr);
        return addr != 0 && mpend[addr] && !(wb_en && int'(wb_addr) == addr);
    endfunction

    function automatic bit mhazard(input logic [15:0] instr);
        int op = int'(instr[15:13]);
        if (op > 2) return 1'b0;
        if (blocked(int'(instr[9:7]))) return 1'b1;
        return (op == 0) && blocked(int'(instr[6:4]));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string name, input bundle_t e);
        chk({name, ".valid"}, 16'(out_valid), 16'd1);
        chk({name, ".a"}, alu_a, e.a);
        chk({name, ".b"}, alu_b, e.b);
        chk({name, ".op"}, 16'(alu_opcode), 16'(e.op));
        chk({name, ".rd"}, 16'(alu_rd), 16'(e.rd));
        chk({name, ".wen"}, 16'(alu_wen), 16'(e.wen));
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".valid"}, 16'(out_valid), 16'd0);
        chk({name, ".a"}, alu_a, 16'd0);
        chk({name, ".b"}, alu_b, 16'd0);
        chk({name, ".op"}, 16'(alu_opcode), 16'd0);
        chk({name, ".rd"}, 16'(alu_rd), 16'd0);
        chk({name, ".wen"}, 16'(alu_wen), 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [15:0] data);
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input string name, input logic [15:0] instr, input bundle_t e);
        in_instr = instr; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        $display("%s instr %h -> a %h b %h op %0d rd %0d wen %0d", name, instr,
                 alu_a, alu_b, alu_opcode, alu_rd, alu_wen);
        chk_bundle(name, e);
    endtask

    vec_t vecs [10];
    bundle_t exp_b;
    bit exp_ready;
    bundle_t bp_a;

    initial begin
        // Reset state
        tick();
        chk_zero("reset");
        chk("reset.in_ready", 16'(in_ready), 16'd1);
        rst = 1'b0;
        wb(3'd1, 16'd5);
        wb(3'd2, 16'd7);

`ifndef DECODE_SCOREBOARD_EN
        vecs[0] = '{1'b0, 3'd0, 16'd0,      enc(3'd0, 3'd3, 3'd1, 7'h20), mk(16'd5,      16'd7,      3'd0, 3'd3, 1'b1)};
        vecs[1] = '{1'b0, 3'd0, 16'd0,      enc(3'd2, 3'd4, 3'd1, 7'h7F), mk(16'd5,      16'hFFFF,   3'd2, 3'd4, 1'b1)};
        vecs[2] = '{1'b0, 3'd0, 16'd0,      enc(3'd1, 3'd4, 3'd1, 7'h3F), mk(16'd5,      16'd63,     3'd1, 3'd4, 1'b1)};
        vecs[3] = '{1'b1, 3'd1, 16'd100,    enc(3'd1, 3'd2, 3'd1, 7'h01), mk(16'd100,    16'd1,      3'd1, 3'd2, 1'b1)};
        vecs[4] = '{1'b1, 3'd0, 16'd55,     enc(3'd0, 3'd5, 3'd0, 7'h00), mk(16'd0,      16'd0,      3'd0, 3'd5, 1'b1)};
        vecs[5] = '{1'b0, 3'd0, 16'd0,      enc(3'd1, 3'd6, 3'd0, 7'h40), mk(16'd0,      16'hFFC0,   3'd1, 3'd6, 1'b1)};
        vecs[6] = '{1'b0, 3'd0, 16'd0,      enc(3'd5, 3'd7, 3'd1, 7'h15), mk(16'd0,      16'd0,      3'd5, 3'd7, 1'b0)};
        vecs[7] = '{1'b0, 3'd0, 16'd0,      enc(3'd0, 3'd0, 3'd1, 7'h20), mk(16'd100,    16'd7,      3'd0, 3'd0, 1'b1)};
        vecs[8] = '{1'b1, 3'd2, 16'h1234,   enc(3'd0, 3'd1, 3'd2, 7'h2F), mk(16'h1234,   16'h1234,   3'd0, 3'd1, 1'b1)};
        vecs[9] = '{1'b0, 3'd0, 16'd0,      enc(3'd0, 3'd7, 3'd1, 7'h00), mk(16'd100,    16'd0,      3'd0, 3'd7, 1'b1)};
        for (int i = 0; i < 10; i++) begin
            wb_en = vecs[i].wbe; wb_addr = vecs[i].wba; wb_data = vecs[i].wbd;
            issue($sformatf("vec%0d", i), vecs[i].instr, vecs[i].exp);
            wb_en = 1'b0;
        end

        // Backpressure: hold one bundle for three cycles, then drain back-to-back
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp.drain", 16'(out_valid), 16'd0);
        bp_a = mk(16'h1234, 16'd5, 3'd1, 3'd3, 1'b1);
        in_instr = enc(3'd1, 3'd3, 3'd2, 7'h05); in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("bp.ready_empty", 16'(in_ready), 16'd1);
        tick();
        chk_bundle("bp.load", bp_a);
        in_instr = enc(3'd2, 3'd4, 3'd1, 7'h7E);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.stall%0d.in_ready", c), 16'(in_ready), 16'd0);
            tick();
            $display("bp stall %0d a %h b %h", c, alu_a, alu_b);
            chk_bundle($sformatf("bp.hold%0d", c), bp_a);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 16'(in_ready), 16'd1);
        tick();
        chk_bundle("bp.second", mk(16'd100, 16'hFFFE, 3'd2, 3'd4, 1'b1));
        in_instr = enc(3'd0, 3'd5, 3'd1, 7'h20);
        tick();
        chk_bundle("bp.third", mk(16'd100, 16'h1234, 3'd0, 3'd5, 1'b1));
        in_valid = 1'b0;
        tick();
        chk("bp.empty", 16'(out_valid), 16'd0);
`endif

        // Randomized traffic from a clean reset
        #2 rst = 1'b1;
        in_valid = 1'b0; wb_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mregs[i] = 16'd0;
            mpend[i] = 1'b0;
        end
        mvalid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_addr   = 3'($urandom_range(0, 7));
            wb_data   = 16'($urandom);
            in_instr  = 16'($urandom);
            in_instr[15:13] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7))
                                                          : 3'($urandom_range(0, 2));
            #1;
            exp_ready = !mvalid || out_ready;
`ifdef DECODE_SCOREBOARD_EN
            exp_ready = exp_ready && !mhazard(in_instr);
`endif
            chk("rnd.in_ready", 16'(in_ready), 16'(exp_ready));
            exp_b = mdecode(in_instr);
            @(posedge clk);
            if (in_valid && exp_ready) begin
                mvalid = 1'b1;
                mb = exp_b;
            end else if (out_ready) begin
                mvalid = 1'b0;
            end
            if (wb_en && wb_addr != 3'd0) begin
                mpend[wb_addr] = 1'b0;
                mregs[wb_addr] = wb_data;
            end
            if (in_valid && exp_ready && exp_b.wen && exp_b.rd != 3'd0) mpend[exp_b.rd] = 1'b1;
            #1;
            chk("rnd.out_valid", 16'(out_valid), 16'(mvalid));
            if (mvalid && in_valid && exp_ready) begin
                $display("rnd %0d instr %h -> a %h b %h", cyc, in_instr, alu_a, alu_b);
                chk_bundle("rnd", mb);
            end
        end
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        tick();

        // Reset while a bundle and a writeback are in flight
        issue("rst.pre", enc(3'd1, 3'd1, 3'd0, 7'h05), mk(16'd0, 16'd5, 3'd1, 3'd1, 1'b1));
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'd77;
        #2 rst = 1'b1;
        #1;
        chk_zero("rst.async");
        tick();
        rst = 1'b0; wb_en = 1'b0;
        issue("rst.r12", enc(3'd0, 3'd0, 3'd1, 7'h20), mk(16'd0, 16'd0, 3'd0, 3'd0, 1'b1));
        issue("rst.r34", enc(3'd0, 3'd0, 3'd3, 7'h40), mk(16'd0, 16'd0, 3'd0, 3'd0, 1'b1));
        issue("rst.r56", enc(3'd0, 3'd0, 3'd5, 7'h60), mk(16'd0, 16'd0, 3'd0, 3'd0, 1'b1));
        issue("rst.r77", enc(3'd0, 3'd0, 3'd7, 7'h70), mk(16'd0, 16'd0, 3'd0, 3'd0, 1'b1));

`ifdef DECODE_SCOREBOARD_EN
        // RAW stall on r3 until its writeback arrives, then bypass
        wb(3'd1, 16'd5);
        in_instr = enc(3'd0, 3'd3, 3'd1, 7'h10); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("sb.first.in_ready", 16'(in_ready), 16'd1);
        tick();
        chk_bundle("sb.first", mk(16'd5, 16'd5, 3'd0, 3'd3, 1'b1));
        in_instr = enc(3'd0, 3'd5, 3'd3, 7'h10);
        #1;
        chk("sb.stall0", 16'(in_ready), 16'd0);
        tick();
        chk("sb.drained", 16'(out_valid), 16'd0);
        chk("sb.stall1", 16'(in_ready), 16'd0);
        tick();
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'd42;
        #1;
        chk("sb.release", 16'(in_ready), 16'd1);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        $display("sb second -> a %h b %h", alu_a, alu_b);
        chk_bundle("sb.second", mk(16'd42, 16'd5, 3'd0, 3'd5, 1'b1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
